fb_arbiter_responder: RTL and testbench
=======================================

Name: fb_arbiter_responder

Overview:
- Responder end of the framebuffer read interface: services VGA-side `fb_access`/`fb_address` requests with `fb_ack`/`fb_data`.
- Also services CPU-side framebuffer reads and writes, so both share one single-port synchronous framebuffer RAM.
- Arbitrates between the two requesters: the VGA display path has priority, with a bounded-burst fairness rule so the CPU is never starved.

Parameters:
- ADDR_W, 15, RAM word-address width; request addresses are truncated to the low ADDR_W bits.
- VGA_BURST, 4, maximum consecutive VGA grants while a CPU request is pending, before one CPU grant is forced.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- fb_access  in  1  VGA read request; held high until fb_ack.
- fb_address  in  16  VGA word address.
- fb_ack  out  1  one-cycle pulse; fb_data is valid in the same cycle.
- fb_data  out  16  VGA read data, registered.
- cpu_access  in  1  CPU request; held high until cpu_ack.
- cpu_wr_en  in  1  1 = write, 0 = read.
- cpu_bytesel  in  2  byte enables for writes; [0] = low byte.
- cpu_address  in  16  CPU word address.
- cpu_wr_data  in  16  CPU write data.
- cpu_rd_data  out  16  CPU read data, registered; valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- ram_addr  out  ADDR_W  RAM address.
- ram_wr_en  out  1  RAM write strobe.
- ram_be  out  2  RAM byte enables.
- ram_wdata  out  16  RAM write data.
- ram_rdata  in  16  RAM read data, valid the cycle after the address is presented.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - fb_ack = 0, cpu_ack = 0, ram_wr_en = 0, ram_be = 0.
  - fb_data = 0, cpu_rd_data = 0.
  - State = IDLE, burst counter = 0.
- FSM states: IDLE, VGA_RD, CPU_RD, ACK.
- IDLE:
  - Evaluate requests; ram_addr, ram_wr_en, ram_be and ram_wdata are driven combinationally from the winner in the same cycle.
  - Only fb_access -> VGA wins.
  - Only cpu_access -> CPU wins.
  - Both -> VGA wins unless burst counter == VGA_BURST, in which case CPU wins.
  - Burst counter increments on a VGA grant while cpu_access is high, and clears on any CPU grant or when cpu_access is low.
- VGA grant: go to VGA_RD. In VGA_RD, capture ram_rdata into fb_data, pulse fb_ack next cycle, go to ACK. Latency from grant cycle N to fb_ack is N+2.
- CPU read: same path via CPU_RD; cpu_ack at N+2.
- CPU write:
  - ram_wr_en = 1 and ram_be = cpu_bytesel in the grant cycle.
  - cpu_ack at N+1 via ACK.
  - cpu_bytesel = 0 still completes and acks; ram_wr_en is asserted with ram_be = 0.
- ACK: one cycle with the relevant ack high; both *_access inputs are ignored in this cycle. Return to IDLE.
- Throughput: one transaction at a time; no pipelining between requesters.
- Reset mid-operation: state returns to IDLE and any pending ack is suppressed. A write already strobed to RAM stands.
- Address wrap: addresses are truncated, not range-checked. Example with ADDR_W = 15: 0x8000 aliases 0x0000.
- Data width: only cpu_rd_data and fb_data are updated on completion; both hold their value otherwise.

Optional Feature:
- Macro: FB_ARBITER_LAST_WORD_EN.
- Defined:
  - One-entry VGA last-word cache (tag ADDR_W bits, data 16, valid bit).
  - Hit in IDLE (fb_access && valid && tag match): go straight to ACK with fb_data = cached data, with no RAM access; fb_ack at N+1. A hit does not consume a burst slot.
  - Every VGA RAM read refills the cache.
  - A CPU write to the cached address merges the written bytes per cpu_bytesel.
  - Reset clears valid.
- Undefined: no cache; all VGA reads take the RAM path.

Decomposition:
- Shared package fb_pkg:
  - FSM state enum.
  - FB_WORD_W = 16 constant.
  - Default ADDR_W constant.
- Natural sub-module: fb_last_word_cache (tag compare, byte-merge on write, refill), instantiated only under FB_ARBITER_LAST_WORD_EN.

Test Plan:
- Lone VGA read: fb_address = 0x0123, RAM word 0x0123 = 0xBEEF -> fb_ack exactly 2 cycles after grant, fb_data = 0xBEEF, cpu_ack stays 0.
- CPU byte write: address 0x0010, data 0xAA55, bytesel = 2'b10 -> ram_be = 2'b10 in the grant cycle, cpu_ack 1 cycle later; a following VGA read returns 0xAAxx with the low byte unchanged.
- Contention: fb_access and cpu_access held high continuously, VGA_BURST = 4 -> grant order V,V,V,V,C,V,V,V,V,C; each ack is a single-cycle pulse.
- Address wrap: CPU writes 0x1234 to 0x8000 -> VGA read of 0x0000 returns 0x1234.
- Reset asserted in VGA_RD -> no fb_ack, state IDLE next cycle, all outputs at reset values.
- With FB_ARBITER_LAST_WORD_EN: two reads of 0x0040 -> second fb_ack 1 cycle after request with no RAM access; after a CPU write 0x00FF, bytesel = 01 to 0x0040, the next hit returns the merged word.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer arbiter/responder slice.
package fb_pkg;

  localparam int FB_WORD_W    = 16;
  localparam int FB_ADDR_W    = 15;
  localparam int FB_VGA_BURST = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VGA_RD = 2'd1,
    ST_CPU_RD = 2'd2,
    ST_ACK    = 2'd3
  } fb_state_e;

  // Byte-lane merge used by both the RAM write path and the last-word cache.
  function automatic logic [FB_WORD_W-1:0] fb_merge_bytes(
    input logic [FB_WORD_W-1:0] old_word,
    input logic [FB_WORD_W-1:0] new_word,
    input logic [1:0]           be
  );
    logic [FB_WORD_W-1:0] merged;
    merged = old_word;
    if (be[0]) merged[7:0]  = new_word[7:0];
    if (be[1]) merged[15:8] = new_word[15:8];
    return merged;
  endfunction

endpackage

// File: rtl/fb_arbiter_responder_if.sv
// Bus bundle between the VGA/CPU requesters, the responder and the framebuffer RAM.
interface fb_arbiter_responder_if #(
  parameter int ADDR_W = fb_pkg::FB_ADDR_W
);
  import fb_pkg::*;

  logic                 fb_access;
  logic [15:0]          fb_address;
  logic                 fb_ack;
  logic [FB_WORD_W-1:0] fb_data;

  logic                 cpu_access;
  logic                 cpu_wr_en;
  logic [1:0]           cpu_bytesel;
  logic [15:0]          cpu_address;
  logic [FB_WORD_W-1:0] cpu_wr_data;
  logic [FB_WORD_W-1:0] cpu_rd_data;
  logic                 cpu_ack;

  logic [ADDR_W-1:0]    ram_addr;
  logic                 ram_wr_en;
  logic [1:0]           ram_be;
  logic [FB_WORD_W-1:0] ram_wdata;
  logic [FB_WORD_W-1:0] ram_rdata;

  modport slave (
    input  fb_access, fb_address,
    input  cpu_access, cpu_wr_en, cpu_bytesel, cpu_address, cpu_wr_data,
    input  ram_rdata,
    output fb_ack, fb_data, cpu_rd_data, cpu_ack,
    output ram_addr, ram_wr_en, ram_be, ram_wdata
  );

  modport master (
    output fb_access, fb_address,
    output cpu_access, cpu_wr_en, cpu_bytesel, cpu_address, cpu_wr_data,
    output ram_rdata,
    input  fb_ack, fb_data, cpu_rd_data, cpu_ack,
    input  ram_addr, ram_wr_en, ram_be, ram_wdata
  );

endinterface

// File: rtl/fb_last_word_cache.sv
// One-entry VGA last-word cache: tag compare, refill from RAM reads, byte-merge on CPU writes.
// Instantiated by fb_arbiter_responder only when FB_ARBITER_LAST_WORD_EN is defined.
module fb_last_word_cache
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    i_lookup_addr,
  output logic                 o_hit,
  output logic [FB_WORD_W-1:0] o_data,
  input  logic                 i_refill,
  input  logic [ADDR_W-1:0]    i_refill_addr,
  input  logic [FB_WORD_W-1:0] i_refill_data,
  input  logic                 i_wr,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [1:0]           i_wr_be,
  input  logic [FB_WORD_W-1:0] i_wr_data
);

  logic                 r_valid;
  logic [ADDR_W-1:0]    r_tag;
  logic [FB_WORD_W-1:0] r_data;

  assign o_hit  = r_valid && (r_tag == i_lookup_addr);
  assign o_data = r_data;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset)         r_valid <= 1'b0;
    else if (i_refill) r_valid <= 1'b1;
  end

  // NOTE: tag and data carry no reset; they are ignored until a refill sets r_valid.
  always_ff @(posedge clk) begin
    if (i_refill) begin
      r_tag  <= i_refill_addr;
      r_data <= i_refill_data;
    end else if (i_wr && r_valid && (r_tag == i_wr_addr)) begin
      r_data <= fb_merge_bytes(r_data, i_wr_data, i_wr_be);
    end
  end

endmodule

// File: rtl/fb_arbiter_responder.sv
// Shares one single-port framebuffer RAM between the VGA read path (priority) and CPU reads/writes.
// Optional FB_ARBITER_LAST_WORD_EN adds a one-entry VGA last-word cache.
module fb_arbiter_responder
  import fb_pkg::*;
#(
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int VGA_BURST = FB_VGA_BURST
) (
  input  logic                  clk,
  input  logic                  reset,
  fb_arbiter_responder_if.slave bus
);

  localparam int CNT_W = $clog2(VGA_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(VGA_BURST);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] VGA_RD = ST_VGA_RD;
  localparam logic [1:0] CPU_RD = ST_CPU_RD;
  localparam logic [1:0] ACK    = ST_ACK;

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_burst;
  logic                 r_fb_ack;
  logic                 r_cpu_ack;
  logic [FB_WORD_W-1:0] r_fb_data;
  logic [FB_WORD_W-1:0] r_cpu_rd_data;

  logic                 w_idle;
  logic                 w_cpu_turn;
  logic                 w_vga_turn;
  logic                 w_vga_grant;
  logic                 w_vga_hit;
  logic                 w_vga_ram;
  logic                 w_cpu_grant;
  logic                 w_cpu_wr;
  logic [FB_WORD_W-1:0] w_cache_data;
  logic [ADDR_W-1:0]    w_fb_addr;
  logic [ADDR_W-1:0]    w_cpu_addr;

  assign w_fb_addr  = bus.fb_address[ADDR_W-1:0];
  assign w_cpu_addr = bus.cpu_address[ADDR_W-1:0];

  // CPU wins when alone, or when VGA has used its whole burst while the CPU waited.
  assign w_cpu_turn  = bus.cpu_access && (!bus.fb_access || (r_burst == BURST_MAX));
  assign w_vga_turn  = bus.fb_access && !w_cpu_turn;
  assign w_idle      = (r_state == IDLE) && !reset;
  assign w_vga_grant = w_idle && w_vga_turn;
  assign w_vga_ram   = w_vga_grant && !w_vga_hit;
  assign w_cpu_grant = w_idle && w_cpu_turn;
  assign w_cpu_wr    = w_cpu_grant && bus.cpu_wr_en;

`ifdef FB_ARBITER_LAST_WORD_EN
  logic              w_cache_hit;
  logic [ADDR_W-1:0] r_req_addr;

  always_ff @(posedge clk) begin
    if (w_vga_ram) r_req_addr <= w_fb_addr;
  end

  fb_last_word_cache #(.ADDR_W(ADDR_W)) u_cache (
    .clk           (clk),
    .reset         (reset),
    .i_lookup_addr (w_fb_addr),
    .o_hit         (w_cache_hit),
    .o_data        (w_cache_data),
    .i_refill      (r_state == VGA_RD),
    .i_refill_addr (r_req_addr),
    .i_refill_data (bus.ram_rdata),
    .i_wr          (w_cpu_wr),
    .i_wr_addr     (w_cpu_addr),
    .i_wr_be       (bus.cpu_bytesel),
    .i_wr_data     (bus.cpu_wr_data)
  );

  assign w_vga_hit = w_vga_grant && w_cache_hit;
`else
  assign w_vga_hit    = 1'b0;
  assign w_cache_data = '0;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    bus.ram_addr  = w_cpu_turn ? w_cpu_addr : w_fb_addr;
    bus.ram_wr_en = 1'b0;
    bus.ram_be    = 2'b00;
    bus.ram_wdata = '0;
    if (w_cpu_wr) begin
      bus.ram_wr_en = 1'b1;
      bus.ram_be    = bus.cpu_bytesel;
      bus.ram_wdata = bus.cpu_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_burst <= '0;
    end else if (r_state == IDLE) begin
      if (!bus.cpu_access || w_cpu_grant) r_burst <= '0;
      else if (w_vga_ram)                 r_burst <= r_burst + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_fb_ack      <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_fb_data     <= '0;
      r_cpu_rd_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_vga_hit) begin
            r_fb_data <= w_cache_data;
            r_fb_ack  <= 1'b1;
            r_state   <= ACK;
          end else if (w_vga_ram) begin
            r_state <= VGA_RD;
          end else if (w_cpu_wr) begin
            r_cpu_ack <= 1'b1;
            r_state   <= ACK;
          end else if (w_cpu_grant) begin
            r_state <= CPU_RD;
          end
        end
        VGA_RD: begin
          r_fb_data <= bus.ram_rdata;
          r_fb_ack  <= 1'b1;
          r_state   <= ACK;
        end
        CPU_RD: begin
          r_cpu_rd_data <= bus.ram_rdata;
          r_cpu_ack     <= 1'b1;
          r_state       <= ACK;
        end
        default: begin
          r_fb_ack  <= 1'b0;
          r_cpu_ack <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.fb_ack      = r_fb_ack;
  assign bus.fb_data     = r_fb_data;
  assign bus.cpu_ack     = r_cpu_ack;
  assign bus.cpu_rd_data = r_cpu_rd_data;

endmodule

// File: tb/tb_fb_arbiter_responder.sv
// Self-checking bench for fb_arbiter_responder: directed literal cases, then randomized traffic
// checked every cycle against a transaction-level model (busy-until timing, reference memory).
module tb_fb_arbiter_responder;
  import fb_pkg::*;

  localparam int ADDR_W    = 15;
  localparam int VGA_BURST = 4;
  localparam int DEPTH     = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fb_arbiter_responder_if #(.ADDR_W(ADDR_W)) bus();

  fb_arbiter_responder #(.ADDR_W(ADDR_W), .VGA_BURST(VGA_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Framebuffer RAM: synchronous read, byte-enabled write.
  logic [15:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_wr_en) begin
      if (bus.ram_be[0]) ram_mem[bus.ram_addr][7:0]  <= bus.ram_wdata[7:0];
      if (bus.ram_be[1]) ram_mem[bus.ram_addr][15:8] <= bus.ram_wdata[15:8];
    end
    bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [DEPTH];
  int          cyc = 0;
  int          free_at = 0;
  int          ack_at = -1;
  bit          ack_vga, ack_rd;
  logic [15:0] ack_val;
  logic [15:0] exp_fb_data, exp_cpu_rd;
  int          burst = 0;
  bit          armed = 0;
  bit          c_valid = 0;
  logic [14:0] c_tag;

  always @(negedge clk) begin : monitor
    logic [14:0] a;
    bit          vga_wins, hit, chk_addr, exp_wr;
    logic [1:0]  exp_be;
    logic [14:0] exp_addr;
    logic [15:0] exp_wd;
    cyc++;
    chk_addr = 0; exp_wr = 0; exp_be = 2'b00; exp_addr = '0; exp_wd = '0; hit = 0;
    if (armed) begin
      if (ack_at == cyc) begin
        if (ack_vga)     exp_fb_data = ack_val;
        else if (ack_rd) exp_cpu_rd  = ack_val;
      end
      check("fb_ack", 16'(bus.fb_ack), 16'(ack_at == cyc && ack_vga));
      check("cpu_ack", 16'(bus.cpu_ack), 16'(ack_at == cyc && !ack_vga));
      check("fb_data", bus.fb_data, exp_fb_data);
      check("cpu_rd_data", bus.cpu_rd_data, exp_cpu_rd);
      if (!reset && cyc >= free_at && (bus.fb_access || bus.cpu_access)) begin
        vga_wins = bus.fb_access && !(bus.cpu_access && burst == VGA_BURST);
        if (vga_wins) begin
          a = bus.fb_address[14:0];
`ifdef FB_ARBITER_LAST_WORD_EN
          hit = c_valid && (c_tag == a);
`endif
          ack_vga = 1; ack_val = ref_mem[a];
          if (hit) begin
            ack_at = cyc + 1; free_at = cyc + 2;
            if (!bus.cpu_access) burst = 0;
          end else begin
            chk_addr = 1; exp_addr = a;
            ack_at = cyc + 2; free_at = cyc + 3;
            burst = bus.cpu_access ? burst + 1 : 0;
            c_valid = 1; c_tag = a;
          end
        end else begin
          a = bus.cpu_address[14:0];
          burst = 0; chk_addr = 1; exp_addr = a; ack_vga = 0;
          if (bus.cpu_wr_en) begin
            exp_wr = 1; exp_be = bus.cpu_bytesel; exp_wd = bus.cpu_wr_data;
            if (exp_be[0]) ref_mem[a][7:0]  = exp_wd[7:0];
            if (exp_be[1]) ref_mem[a][15:8] = exp_wd[15:8];
            ack_rd = 0; ack_at = cyc + 1; free_at = cyc + 2;
          end else begin
            ack_rd = 1; ack_val = ref_mem[a]; ack_at = cyc + 2; free_at = cyc + 3;
          end
        end
      end else if (!reset && cyc >= free_at) begin
        burst = 0;
      end
      check("ram_wr_en", 16'(bus.ram_wr_en), 16'(exp_wr));
      check("ram_be", 16'(bus.ram_be), 16'(exp_be));
      if (chk_addr) check("ram_addr", 16'(bus.ram_addr), 16'(exp_addr));
      if (exp_wr)   check("ram_wdata", bus.ram_wdata, exp_wd);
    end
    if (reset) begin
      free_at = cyc + 1; ack_at = -1; exp_fb_data = '0; exp_cpu_rd = '0;
      burst = 0; c_valid = 0; armed = 1;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic preload(input logic [15:0] addr, input logic [15:0] val);
    ram_mem[addr[14:0]] = val;
    ref_mem[addr[14:0]] = val;
  endtask

  task automatic vga_read(input logic [15:0] addr, output logic [15:0] data,
                          output int lat, output bit cpu_seen);
    @(posedge clk); #1;
    bus.fb_access = 1'b1; bus.fb_address = addr;
    lat = -1; cpu_seen = 0; data = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.cpu_ack) cpu_seen = 1;
      if (bus.fb_ack) begin data = bus.fb_data; lat = k; break; end
    end
    @(posedge clk); #1;
    bus.fb_access = 1'b0;
  endtask

  task automatic cpu_op(input bit we, input logic [1:0] be, input logic [15:0] addr,
                        input logic [15:0] wd, output logic [15:0] rd, output int lat,
                        output logic [1:0] be_seen, output bit wr_seen);
    @(posedge clk); #1;
    bus.cpu_access = 1'b1; bus.cpu_wr_en = we; bus.cpu_bytesel = be;
    bus.cpu_address = addr; bus.cpu_wr_data = wd;
    lat = -1; rd = '0; be_seen = 2'b00; wr_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin be_seen = bus.ram_be; wr_seen = bus.ram_wr_en; end
      if (bus.cpu_ack) begin rd = bus.cpu_rd_data; lat = k; break; end
    end
    @(posedge clk); #1;
    bus.cpu_access = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom);
    a[14:5] = '0;
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic [15:0] order;
    logic [1:0]  be_seen;
    int          lat, n;
    bit          flag, wr_seen, fa, ca;

    reset = 1'b1;
    bus.fb_access = 1'b0; bus.fb_address = '0;
    bus.cpu_access = 1'b0; bus.cpu_wr_en = 1'b0; bus.cpu_bytesel = 2'b00;
    bus.cpu_address = '0; bus.cpu_wr_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      d = 16'($urandom);
      ram_mem[i] = d;
      ref_mem[i] = d;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_fb_ack", 16'(bus.fb_ack), 16'd0);
    check("rst_cpu_ack", 16'(bus.cpu_ack), 16'd0);
    check("rst_fb_data", bus.fb_data, 16'h0000);
    check("rst_cpu_rd_data", bus.cpu_rd_data, 16'h0000);
    check("rst_ram_wr_en", 16'(bus.ram_wr_en), 16'd0);

    // Lone VGA read
    preload(16'h0123, 16'hBEEF);
    vga_read(16'h0123, d, lat, flag);
    check("lone_vga_data", d, 16'hBEEF);
    check("lone_vga_latency", 16'(lat), 16'd2);
    check("lone_vga_no_cpu_ack", 16'(flag), 16'd0);

    // CPU byte write then VGA read-back
    preload(16'h0010, 16'h1234);
    cpu_op(1'b1, 2'b10, 16'h0010, 16'hAA55, d, lat, be_seen, wr_seen);
    check("cpu_wr_be", 16'(be_seen), 16'h0002);
    check("cpu_wr_strobe", 16'(wr_seen), 16'd1);
    check("cpu_wr_latency", 16'(lat), 16'd1);
    vga_read(16'h0010, d, lat, flag);
    check("byte_merge_readback", d, 16'hAA34);
    cpu_op(1'b0, 2'b00, 16'h0010, 16'h0000, d, lat, be_seen, wr_seen);
    check("cpu_rd_data", d, 16'hAA34);
    check("cpu_rd_latency", 16'(lat), 16'd2);

    // Address wrap: 0x8000 aliases 0x0000
    cpu_op(1'b1, 2'b11, 16'h8000, 16'h1234, d, lat, be_seen, wr_seen);
    vga_read(16'h0000, d, lat, flag);
    check("addr_wrap", d, 16'h1234);

    // Contention: both held high; bit i of order = 1 when ack i was a CPU ack
    @(posedge clk); #1;
    bus.fb_access = 1'b1; bus.fb_address = 16'h0100;
    bus.cpu_access = 1'b1; bus.cpu_wr_en = 1'b0; bus.cpu_address = 16'h0006;
    order = '0; n = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      @(negedge clk);
      if (bus.fb_ack) begin n++; bus.fb_address = 16'h0100 + 16'(n); end
      if (bus.cpu_ack) begin order[n] = 1'b1; n++; end
    end
    @(posedge clk); #1;
    bus.fb_access = 1'b0; bus.cpu_access = 1'b0;
    check("contention_acks", 16'(n), 16'd10);
    check("contention_order", order, 16'h0210);

    // Reset while in VGA_RD suppresses the pending ack
    @(posedge clk); #1;
    bus.fb_access = 1'b1; bus.fb_address = 16'h0123;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; bus.fb_access = 1'b0;
    @(negedge clk);
    check("midrst_fb_ack", 16'(bus.fb_ack), 16'd0);
    check("midrst_fb_data", bus.fb_data, 16'h0000);
    check("midrst_cpu_rd_data", bus.cpu_rd_data, 16'h0000);
    @(negedge clk);
    check("midrst_fb_ack_late", 16'(bus.fb_ack), 16'd0);

`ifdef FB_ARBITER_LAST_WORD_EN
    preload(16'h0040, 16'h5A5A);
    vga_read(16'h0040, d, lat, flag);
    vga_read(16'h0040, d, lat, flag);
    check("cache_hit_latency", 16'(lat), 16'd1);
    check("cache_hit_data", d, 16'h5A5A);
    cpu_op(1'b1, 2'b01, 16'h0040, 16'h00FF, d, lat, be_seen, wr_seen);
    vga_read(16'h0040, d, lat, flag);
    check("cache_merge_latency", 16'(lat), 16'd1);
    check("cache_merge_data", d, 16'h5AFF);
`endif

    // Randomized traffic, checked cycle by cycle by the monitor
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      fa = bus.fb_ack; ca = bus.cpu_ack;
      @(posedge clk); #1;
      reset = ($urandom_range(0, 149) == 0);
      if (!bus.fb_access || fa) begin
        bus.fb_access  = ($urandom_range(0, 2) != 0);
        bus.fb_address = rand_addr();
      end
      if (!bus.cpu_access || ca) begin
        bus.cpu_access  = ($urandom_range(0, 2) != 0);
        bus.cpu_wr_en   = 1'($urandom);
        bus.cpu_bytesel = 2'($urandom);
        bus.cpu_address = rand_addr();
        bus.cpu_wr_data = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; bus.fb_access = 1'b0; bus.cpu_access = 1'b0;
    repeat (6) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
